// File: rtl/apb_rx_poller_if.sv
// APB bus between the receiver poller (initiator) and the receiver register block.
interface apb_rx_poller_if #(
  parameter int ADDRESSWIDTH = 4,
  parameter int DATAWIDTH    = 16
) ();
  logic [ADDRESSWIDTH-1:0] PADDR_o;
  logic                    PWRITE_o;
  logic                    PSEL_o;
  logic                    PENABLE_o;
  logic [DATAWIDTH-1:0]    PRDATA_i;
  logic                    PREADY_i;

  modport master (
    output PADDR_o, PWRITE_o, PSEL_o, PENABLE_o,
    input  PRDATA_i, PREADY_i
  );

  modport slave (
    input  PADDR_o, PWRITE_o, PSEL_o, PENABLE_o,
    output PRDATA_i, PREADY_i
  );
endinterface

// File: rtl/apb_rx_poller.sv
// APB initiator that polls the receiver status register and, when a frame is
// ready, reads id/data/command/receive registers and presents them downstream.
module apb_rx_poller #(
  parameter int ADDRESSWIDTH = 4,
  parameter int DATAWIDTH    = 16,
  parameter int POLL_GAP     = 8,
  parameter int TIMEOUT      = 64
) (
  input  logic                  PCLK_rx,
  input  logic                  PRESETn_rx,
  input  logic                  enable_i,
  apb_rx_poller_if.master       apb,
  output logic                  frame_valid_o,
  input  logic                  frame_ready_i,
  output logic [7:0]            frame_id_o,
  output logic [15:0]           frame_data_o,
  output logic [7:0]            frame_cmd_o,
  output logic [11:0]           frame_rx_o,
  output logic [7:0]            frame_status_o,
  output logic                  timeout_err_o,
  output logic                  busy_o
);

  localparam int WCW = $clog2(TIMEOUT + 1);
  localparam int GCW = $clog2(POLL_GAP + 1);

  typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_ACCESS, ST_WAIT, ST_OUT} state_e;

  state_e          state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic [WCW-1:0]  wait_cnt_q, wait_cnt_d;
  logic [GCW-1:0]  gap_cnt_q, gap_cnt_d;
  logic            err_q, err_d;
  logic [7:0]      status_q, status_d;
  logic [7:0]      id_q, id_d;
  logic [15:0]     data_q, data_d;
  logic [7:0]      cmd_q, cmd_d;
  logic [7:0]      fstatus_q, fstatus_d;
  logic [7:0]      fid_q, fid_d;
  logic [15:0]     fdata_q, fdata_d;
  logic [7:0]      fcmd_q, fcmd_d;
  logic [11:0]     frx_q, frx_d;

  // Register address for each step of the read sequence.
  function automatic logic [ADDRESSWIDTH-1:0] idx_addr(input logic [2:0] idx);
    case (idx)
      3'd0:    idx_addr = ADDRESSWIDTH'(8);
      3'd1:    idx_addr = ADDRESSWIDTH'(6);
      3'd2:    idx_addr = ADDRESSWIDTH'(7);
      3'd3:    idx_addr = ADDRESSWIDTH'(9);
      default: idx_addr = ADDRESSWIDTH'(5);
    endcase
  endfunction

  // State and datapath registers, asynchronous active-low reset.
  always_ff @(posedge PCLK_rx or negedge PRESETn_rx) begin
    if (!PRESETn_rx) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      wait_cnt_q <= '0;
      gap_cnt_q  <= '0;
      err_q      <= 1'b0;
      status_q   <= '0;
      id_q       <= '0;
      data_q     <= '0;
      cmd_q      <= '0;
      fstatus_q  <= '0;
      fid_q      <= '0;
      fdata_q    <= '0;
      fcmd_q     <= '0;
      frx_q      <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      wait_cnt_q <= wait_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      err_q      <= err_d;
      status_q   <= status_d;
      id_q       <= id_d;
      data_q     <= data_d;
      cmd_q      <= cmd_d;
      fstatus_q  <= fstatus_d;
      fid_q      <= fid_d;
      fdata_q    <= fdata_d;
      fcmd_q     <= fcmd_d;
      frx_q      <= frx_d;
    end
  end

  // Sequencing, field capture and wait/gap counting.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    wait_cnt_d = wait_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    err_d      = err_q;
    status_d   = status_q;
    id_d       = id_q;
    data_d     = data_q;
    cmd_d      = cmd_q;
    fstatus_d  = fstatus_q;
    fid_d      = fid_q;
    fdata_d    = fdata_q;
    fcmd_d     = fcmd_q;
    frx_d      = frx_q;
    case (state_q)
      ST_IDLE: begin
        if (enable_i) begin
          state_d = ST_SETUP;
          idx_d   = '0;
        end else begin
          err_d = 1'b0;
        end
      end
      ST_SETUP: begin
        state_d    = ST_ACCESS;
        wait_cnt_d = '0;
      end
      ST_ACCESS: begin
        if (apb.PREADY_i) begin
          case (idx_q)
            3'd0: begin
              status_d = apb.PRDATA_i[7:0];
              if (apb.PRDATA_i[0] && !apb.PRDATA_i[7]) begin
                state_d = ST_SETUP;
                idx_d   = 3'd1;
              end else begin
                state_d   = ST_WAIT;
                gap_cnt_d = '0;
              end
            end
            3'd1: begin
              id_d    = apb.PRDATA_i[7:0];
              state_d = ST_SETUP;
              idx_d   = 3'd2;
            end
            3'd2: begin
              data_d  = apb.PRDATA_i[15:0];
              state_d = ST_SETUP;
              idx_d   = 3'd3;
            end
            3'd3: begin
              cmd_d   = apb.PRDATA_i[7:0];
              state_d = ST_SETUP;
              idx_d   = 3'd4;
            end
            default: begin
              // Receive value goes straight to the output register; the
              // other fields were staged during the burst.
              fstatus_d = status_q;
              fid_d     = id_q;
              fdata_d   = data_q;
              fcmd_d    = cmd_q;
              frx_d     = apb.PRDATA_i[11:0];
              state_d   = ST_OUT;
            end
          endcase
        end else if (wait_cnt_q == WCW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      ST_WAIT: begin
        if (!enable_i) begin
          state_d = ST_IDLE;
        end else if (gap_cnt_q == GCW'(POLL_GAP - 1)) begin
          state_d = ST_SETUP;
          idx_d   = '0;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      ST_OUT: begin
        if (frame_ready_i) begin
          state_d   = ST_WAIT;
          gap_cnt_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Bus and handshake outputs decoded from the registered state.
  always_comb begin
    apb.PSEL_o    = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
    apb.PENABLE_o = (state_q == ST_ACCESS);
    apb.PWRITE_o  = 1'b0;
    apb.PADDR_o   = apb.PSEL_o ? idx_addr(idx_q) : '0;
    busy_o        = apb.PSEL_o;
    frame_valid_o = (state_q == ST_OUT);
  end

  assign frame_status_o = fstatus_q;
  assign frame_id_o     = fid_q;
  assign frame_data_o   = fdata_q;
  assign frame_cmd_o    = fcmd_q;
  assign frame_rx_o     = frx_q;
  assign timeout_err_o  = err_q;

endmodule

// File: tb/tb_apb_rx_poller.sv
// Scoreboard bench for apb_rx_poller: a register-block model answers reads,
// expected transfers/frames are queued by the stimulus and checked by a monitor.
module tb_apb_rx_poller;
  localparam int AW = 4;
  localparam int DW = 16;
  localparam int PG = 8;
  localparam int TO = 64;

  typedef struct {
    logic [7:0]  id;
    logic [15:0] data;
    logic [7:0]  cmd;
    logic [11:0] rx;
    logic [7:0]  st;
  } frame_t;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        frame_ready;
  logic        frame_valid;
  logic [7:0]  frame_id;
  logic [15:0] frame_data;
  logic [7:0]  frame_cmd;
  logic [11:0] frame_rx;
  logic [7:0]  frame_status;
  logic        timeout_err;
  logic        busy;

  logic [7:0]  r_status, r_id, r_cmd;
  logic [15:0] r_data;
  logic [11:0] r_rx;
  logic        stuck;
  int          stall_req;
  int          stall_done;

  logic [AW-1:0] exp_addr[$];
  frame_t        exp_f[$];
  int checks;
  int errors;

  apb_rx_poller_if #(.ADDRESSWIDTH(AW), .DATAWIDTH(DW)) apb ();

  apb_rx_poller #(.ADDRESSWIDTH(AW), .DATAWIDTH(DW), .POLL_GAP(PG), .TIMEOUT(TO)) dut (
    .PCLK_rx       (clk),
    .PRESETn_rx    (rst_n),
    .enable_i      (enable),
    .apb           (apb),
    .frame_valid_o (frame_valid),
    .frame_ready_i (frame_ready),
    .frame_id_o    (frame_id),
    .frame_data_o  (frame_data),
    .frame_cmd_o   (frame_cmd),
    .frame_rx_o    (frame_rx),
    .frame_status_o(frame_status),
    .timeout_err_o (timeout_err),
    .busy_o        (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, expv);
    end
  endtask

  // Register block model: answers on the address driven, stalls address 7 on request.
  initial begin
    stall_done   = 0;
    apb.PRDATA_i = '0;
    apb.PREADY_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (apb.PADDR_o)
        4'd8:    apb.PRDATA_i = {8'h99, r_status};
        4'd6:    apb.PRDATA_i = {8'hEE, r_id};
        4'd7:    apb.PRDATA_i = r_data;
        4'd9:    apb.PRDATA_i = {8'h77, r_cmd};
        4'd5:    apb.PRDATA_i = {4'hF, r_rx};
        default: apb.PRDATA_i = 16'hDEAD;
      endcase
      if (apb.PSEL_o && apb.PENABLE_o && apb.PADDR_o == 4'd7 && stall_done < stall_req) begin
        apb.PREADY_i = 1'b0;
        stall_done++;
      end else begin
        apb.PREADY_i = !stuck;
      end
    end
  end

  // Monitor: compares every completed transfer and accepted frame with the queues.
  initial begin : monitor
    logic [AW-1:0] setup_addr;
    frame_t        f;
    setup_addr = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (!apb.PSEL_o) begin
          chk("paddr_idle", 32'(apb.PADDR_o), 32'd0);
          chk("penable_idle", 32'(apb.PENABLE_o), 32'd0);
        end else if (!apb.PENABLE_o) begin
          setup_addr = apb.PADDR_o;
        end else begin
          chk("paddr_stable", 32'(apb.PADDR_o), 32'(setup_addr));
          if (apb.PREADY_i) begin
            chk("pwrite", 32'(apb.PWRITE_o), 32'd0);
            if (exp_addr.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL xfer_unexpected actual=%0h required=none", apb.PADDR_o);
            end else begin
              chk("xfer_addr", 32'(apb.PADDR_o), 32'(exp_addr.pop_front()));
            end
          end
        end
        if (frame_valid && frame_ready) begin
          if (exp_f.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL frame_unexpected actual=%0h required=none", frame_id);
          end else begin
            f = exp_f.pop_front();
            chk("frame_id", 32'(frame_id), 32'(f.id));
            chk("frame_data", 32'(frame_data), 32'(f.data));
            chk("frame_cmd", 32'(frame_cmd), 32'(f.cmd));
            chk("frame_rx", 32'(frame_rx), 32'(f.rx));
            chk("frame_status", 32'(frame_status), 32'(f.st));
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Counts cycles until a condition holds (0: SETUP, 1: frame_valid, 2: timeout_err).
  task automatic wait_cond(input string nm, input int which, input int exp_n);
    int  n;
    bit  seen;
    n    = 0;
    seen = 1'b0;
    for (int i = 1; i <= 200 && !seen; i++) begin
      step();
      n = i;
      case (which)
        0:       seen = apb.PSEL_o && !apb.PENABLE_o;
        1:       seen = frame_valid;
        default: seen = timeout_err;
      endcase
    end
    chk(nm, 32'(n), 32'(exp_n));
  endtask

  task automatic push_burst(input logic [7:0] st, input logic [7:0] id, input logic [15:0] d,
                            input logic [7:0] c, input logic [11:0] rx);
    frame_t f;
    exp_addr.push_back(4'd8);
    exp_addr.push_back(4'd6);
    exp_addr.push_back(4'd7);
    exp_addr.push_back(4'd9);
    exp_addr.push_back(4'd5);
    f.id = id; f.data = d; f.cmd = c; f.rx = rx; f.st = st;
    exp_f.push_back(f);
    r_status = st; r_id = id; r_data = d; r_cmd = c; r_rx = rx;
  endtask

  initial begin
    checks = 0; errors = 0;
    r_status = 8'h00; r_id = '0; r_data = '0; r_cmd = '0; r_rx = '0;
    stuck = 1'b0; stall_req = 0;
    rst_n = 1'b0; enable = 1'b1; frame_ready = 1'b1;
    repeat (3) step();

    // Reset values
    chk("rst_psel", 32'(apb.PSEL_o), 32'd0);
    chk("rst_penable", 32'(apb.PENABLE_o), 32'd0);
    chk("rst_paddr", 32'(apb.PADDR_o), 32'd0);
    chk("rst_valid", 32'(frame_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(timeout_err), 32'd0);
    chk("rst_fid", 32'(frame_id), 32'd0);
    chk("rst_fdata", 32'(frame_data), 32'd0);
    chk("rst_frx", 32'(frame_rx), 32'd0);

    // Not-ready status: periodic polling of address 8 only
    repeat (3) exp_addr.push_back(4'd8);
    rst_n = 1'b1;
    wait_cond("poll_first", 0, 1);
    wait_cond("poll_period", 0, PG + 2);
    wait_cond("poll_period2", 0, PG + 2);
    enable = 1'b0;
    repeat (12) step();
    chk("poll_busy_idle", 32'(busy), 32'd0);

    // Ready frame, PREADY always high
    push_burst(8'h01, 8'h3C, 16'hBEEF, 8'h5A, 12'hABC);
    enable = 1'b1;
    wait_cond("frame_latency", 1, 11);
    enable = 1'b0;
    repeat (12) step();

    // Receiver busy bit set: status polls only
    r_status = 8'h81;
    exp_addr.push_back(4'd8);
    exp_addr.push_back(4'd8);
    enable = 1'b1;
    wait_cond("busy_poll_first", 0, 1);
    wait_cond("busy_poll_period", 0, PG + 2);
    enable = 1'b0;
    repeat (12) step();
    chk("busy_no_valid", 32'(frame_valid), 32'd0);

    // Three wait states on the data-field read
    stall_req = 3;
    push_burst(8'h01, 8'hC3, 16'h1234, 8'hA5, 12'h123);
    enable = 1'b1;
    wait_cond("stall_latency", 1, 14);
    enable = 1'b0;
    repeat (12) step();

    // Downstream back-pressure, then gap before next poll
    frame_ready = 1'b0;
    push_burst(8'h01, 8'h11, 16'h2222, 8'h33, 12'h444);
    enable = 1'b1;
    wait_cond("hold_latency", 1, 11);
    r_status = 8'h00;
    exp_addr.push_back(4'd8);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_valid", 32'(frame_valid), 32'd1);
      chk("hold_id", 32'(frame_id), 32'h11);
      chk("hold_data", 32'(frame_data), 32'h2222);
      chk("hold_rx", 32'(frame_rx), 32'h444);
      chk("hold_psel", 32'(apb.PSEL_o), 32'd0);
    end
    frame_ready = 1'b1;
    step();
    chk("hold_drop_valid", 32'(frame_valid), 32'd0);
    wait_cond("gap_after_frame", 0, PG);
    enable = 1'b0;
    repeat (12) step();

    // PREADY stuck low: timeout abort
    stuck = 1'b1;
    enable = 1'b1;
    wait_cond("to_setup", 0, 1);
    wait_cond("to_latency", 2, TO + 1);
    chk("to_psel", 32'(apb.PSEL_o), 32'd0);
    chk("to_penable", 32'(apb.PENABLE_o), 32'd0);
    chk("to_busy", 32'(busy), 32'd0);
    chk("to_valid", 32'(frame_valid), 32'd0);
    enable = 1'b0;
    stuck = 1'b0;
    step();
    chk("to_clear", 32'(timeout_err), 32'd0);
    repeat (4) step();

    // Asynchronous reset during ACCESS, then restart from status read
    enable = 1'b1;
    wait_cond("rst_setup", 0, 1);
    step();
    chk("rst_in_access", 32'(apb.PENABLE_o), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_psel", 32'(apb.PSEL_o), 32'd0);
    chk("arst_penable", 32'(apb.PENABLE_o), 32'd0);
    chk("arst_valid", 32'(frame_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    exp_addr.push_back(4'd8);
    step();
    rst_n = 1'b1;
    wait_cond("restart_setup", 0, 1);
    chk("restart_paddr", 32'(apb.PADDR_o), 32'd8);
    enable = 1'b0;
    repeat (12) step();

    chk("addr_q_empty", 32'(exp_addr.size()), 32'd0);
    chk("frame_q_empty", 32'(exp_f.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/apb_rx_poller.md
Name: apb_rx_poller

Overview:
- APB initiator (master) for the receiver register block in the PCLK_rx domain.
- Polls the receiver status register. When a frame is ready, it reads id, data field, command and receive registers in a fixed burst.
- Presents the collected frame to downstream logic on a valid/ready interface.
- The final read of the receive register (address 5) is what generates the responder's read_enable acknowledge.

Parameters:
- ADDRESSWIDTH, 4, APB address width. Must hold address 9.
- DATAWIDTH, 16, APB read-data width. Minimum 16.
- POLL_GAP, 8, idle cycles between a not-ready status read and the next status read. Minimum 1.
- TIMEOUT, 64, maximum ACCESS cycles with PREADY low before the sequence is aborted.

Ports:
- PCLK_rx  input  1  clock
- PRESETn_rx  input  1  asynchronous active-low reset
- enable_i  input  1  polling enable
- PADDR_o  output  ADDRESSWIDTH  APB address
- PWRITE_o  output  1  APB write; held 0
- PSEL_o  output  1  APB select
- PENABLE_o  output  1  APB enable
- PRDATA_i  input  DATAWIDTH  APB read data
- PREADY_i  input  1  APB ready
- frame_valid_o  output  1  frame available
- frame_ready_i  input  1  downstream accepts frame
- frame_id_o  output  8  PRDATA[7:0] from address 6
- frame_data_o  output  16  PRDATA[15:0] from address 7
- frame_cmd_o  output  8  PRDATA[7:0] from address 9
- frame_rx_o  output  12  PRDATA[11:0] from address 5
- frame_status_o  output  8  status value captured at sequence start
- timeout_err_o  output  1  sticky PREADY-timeout flag
- busy_o  output  1  high in SETUP or ACCESS

Behaviour:
- Interface decision: reset PRESETn_rx, asynchronous, active-low; clock PCLK_rx.
- Reset values: all outputs 0; state IDLE; sequence index 0; all counters 0.
- Reset asserted mid-transfer drops PSEL_o and PENABLE_o immediately.
- States: IDLE, SETUP, ACCESS, WAIT, OUT.
- Address sequence, by index:
  - 0: status, address 8
  - 1: id, address 6
  - 2: data field, address 7
  - 3: command, address 9
  - 4: receive, address 5
- IDLE:
  - enable_i=1 → SETUP with index 0.
  - Otherwise stay in IDLE.
- SETUP (one cycle):
  - PSEL_o=1, PENABLE_o=0, PADDR_o = address for the current index.
  - Always → ACCESS.
- ACCESS:
  - PSEL_o=1, PENABLE_o=1, PADDR_o stable.
  - A transfer completes on the rising edge where PREADY_i=1; PRDATA_i is sampled on that edge into the field for the current index.
  - While PREADY_i=0, the wait counter increments.
  - Wait counter reaches TIMEOUT: timeout_err_o set, PSEL_o/PENABLE_o drop next cycle, state → IDLE, captured fields discarded, frame_valid_o not asserted.
- After the index-0 (status) completion:
  - PRDATA[0]=1 and PRDATA[7]=0: frame ready and receiver not busy → SETUP with index 1 (back-to-back; PENABLE_o low for one cycle).
  - Otherwise → WAIT.
- Index 1 to 3 completions → SETUP with the next index.
- Index 4 completion → OUT. Output registers load on that edge; frame_valid_o=1 from the next cycle.
- OUT:
  - frame_valid_o held high and frame_* held stable until frame_valid_o & frame_ready_i on a rising edge.
  - Then frame_valid_o=0 and state → WAIT. The gap gives the responder time to clear status.
  - No APB activity in OUT.
- WAIT:
  - Counts POLL_GAP cycles.
  - At the end, if enable_i=1 → SETUP with index 0; else → IDLE.
  - enable_i=0 during WAIT → IDLE immediately.
- enable_i deasserted during SETUP or ACCESS: the in-flight burst completes, including OUT. enable_i is only sampled in IDLE and WAIT.
- timeout_err_o clears only on reset or when enable_i=0 in IDLE.
- Latency, with PREADY_i always 1: enable_i edge → first SETUP in 1 cycle. A ready frame is 5 transfers × 2 cycles = 10 cycles from the first SETUP; frame_valid_o follows in cycle 11.
- PWRITE_o is never 1. PADDR_o is 0 outside SETUP and ACCESS.

Test Plan:
- Reset with enable_i=1, PREADY=1, status=0x00 → status reads at address 8 separated by WAIT gaps; SETUP-to-SETUP period = 2+POLL_GAP cycles; frame_valid_o stays 0.
- Status=0x01, id=0x3C, data=0xBEEF, cmd=0x5A, rx=0xABC, PREADY=1 → addresses 8,6,7,9,5 in order, each SETUP then ACCESS; frame_valid_o in cycle 11; outputs 0x3C, 0xBEEF, 0x5A, 0xABC, status 0x01.
- Status=0x81 (busy bit set) → no burst; returns to WAIT; only address 8 is ever driven.
- PREADY held low 3 cycles on the address-7 read → ACCESS extends 3 cycles with PADDR=7 stable; frame data still correct.
- PREADY held low indefinitely → after 64 ACCESS cycles, timeout_err_o=1, bus idles, state IDLE; clears when enable_i=0.
- frame_ready_i low 5 cycles after valid → frame outputs stable, no APB activity. Then ready pulses high → valid drops next cycle; next status poll after POLL_GAP cycles.
- Reset asserted during ACCESS → PSEL/PENABLE/frame_valid_o go to 0 asynchronously; polling restarts from address 8 after release.
